// File: rtl/npc_unit.sv
// npc_unit: PC register and next-PC sequencer (branch/jump/jr/exception).
// Define DELAY_SLOT_EN for architectural single-delay-slot redirects.
module npc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        j_valid,
    input  logic [25:0] j_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        exc_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        misalign
);

    logic        redir;
    logic [31:0] target;
    logic        jr_bad;

    assign pc_plus4 = pc + 32'd4;
    assign jr_bad   = jr_valid && (jr_target[1:0] != 2'b00);

    always_comb begin
        redir  = 1'b0;
        target = pc_plus4;
        if (jr_valid) begin
            redir  = 1'b1;
            target = jr_target;
        end else if (j_valid) begin
            redir  = 1'b1;
            target = {pc_plus4[31:28], j_index, 2'b00};
        end else if (br_taken) begin
            redir  = 1'b1;
            target = pc_plus4 + br_offset;
        end
    end

`ifdef DELAY_SLOT_EN
    typedef enum logic {RUN, DSLOT} state_t;
    state_t      state;
    logic [31:0] tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            state    <= RUN;
            tgt      <= '0;
            flush    <= 1'b0;
            misalign <= 1'b0;
        end else begin
            flush    <= 1'b0;
            misalign <= 1'b0;
            if (exc_valid) begin
                pc    <= EXC_PC;
                state <= RUN;
                tgt   <= '0;
                flush <= 1'b1;
            end else if (stall) begin
                pc    <= pc;
            end else if (state == DSLOT) begin
                // Requests from the slot instruction are dropped
                pc    <= tgt;
                state <= RUN;
            end else if (jr_bad) begin
                pc       <= EXC_PC;
                tgt      <= '0;
                flush    <= 1'b1;
                misalign <= 1'b1;
            end else if (redir) begin
                tgt   <= target;
                pc    <= pc_plus4;
                state <= DSLOT;
            end else begin
                pc <= pc_plus4;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            flush    <= 1'b0;
            misalign <= 1'b0;
        end else begin
            flush    <= 1'b0;
            misalign <= 1'b0;
            if (exc_valid) begin
                pc    <= EXC_PC;
                flush <= 1'b1;
            end else if (stall) begin
                pc <= pc;
            end else if (jr_bad) begin
                pc       <= EXC_PC;
                flush    <= 1'b1;
                misalign <= 1'b1;
            end else if (redir) begin
                pc    <= target;
                flush <= 1'b1;
            end else begin
                pc <= pc_plus4;
            end
        end
    end
`endif

endmodule

// File: tb/tb_npc_unit.sv
// Scoreboard testbench for npc_unit; expectations follow DELAY_SLOT_EN.
module tb_npc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        j_valid;
    logic [25:0] j_index;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic        exc_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        misalign;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic        f;
        logic        m;
        string       nm;
    } exp_t;

    exp_t sb[$];

    npc_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .br_taken(br_taken), .br_offset(br_offset),
        .j_valid(j_valid), .j_index(j_index),
        .jr_valid(jr_valid), .jr_target(jr_target),
        .exc_valid(exc_valid), .pc(pc), .pc_plus4(pc_plus4),
        .flush(flush), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every negedge with a pending expectation is compared
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.nm, ".pc"}, pc, e.pc);
            chk({e.nm, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
            chk({e.nm, ".flush"}, {31'd0, flush}, {31'd0, e.f});
            chk({e.nm, ".misalign"}, {31'd0, misalign}, {31'd0, e.m});
        end
    end

    task automatic clr();
        rst = 1'b0; stall = 1'b0;
        br_taken = 1'b0; br_offset = '0;
        j_valid = 1'b0; j_index = '0;
        jr_valid = 1'b0; jr_target = '0;
        exc_valid = 1'b0;
    endtask

    task automatic cyc(input logic [31:0] p, input logic f, input logic m, input string nm);
        exp_t e;
        @(posedge clk);
        e.pc = p; e.f = f; e.m = m; e.nm = nm;
        sb.push_back(e);
        #1;
        clr();
    endtask

    initial begin
        clr();
        rst = 1'b1;
        cyc(32'h3000, 0, 0, "reset");
        cyc(32'h3004, 0, 0, "seq1");
        cyc(32'h3008, 0, 0, "seq2");
        cyc(32'h300C, 0, 0, "seq3");
        cyc(32'h3010, 0, 0, "seq4");

        br_taken = 1'b1; br_offset = 32'hFFFF_FFF0;
`ifdef DELAY_SLOT_EN
        cyc(32'h3014, 0, 0, "br_slot");
        cyc(32'h3004, 0, 0, "br_tgt");
`else
        cyc(32'h3004, 1, 0, "br");
`endif
        cyc(32'h3008, 0, 0, "br_after");
        cyc(32'h300C, 0, 0, "seq5");
        cyc(32'h3010, 0, 0, "seq6");

        j_valid = 1'b1; j_index = 26'h000_0C10;
        br_taken = 1'b1; br_offset = 32'hFFFF_FFF0;
`ifdef DELAY_SLOT_EN
        cyc(32'h3014, 0, 0, "j_slot");
        cyc(32'h3040, 0, 0, "j_tgt");
`else
        cyc(32'h3040, 1, 0, "j_over_br");
`endif

        jr_valid = 1'b1; jr_target = 32'h3021;
        cyc(32'h4180, 1, 1, "jr_misalign");
        cyc(32'h4184, 0, 0, "jr_mis_after");

        jr_valid = 1'b1; jr_target = 32'h3020;
`ifdef DELAY_SLOT_EN
        cyc(32'h4188, 0, 0, "jr_slot");
        cyc(32'h3020, 0, 0, "jr_tgt");
`else
        cyc(32'h3020, 1, 0, "jr");
`endif

        exc_valid = 1'b1; jr_valid = 1'b1; jr_target = 32'h3000;
        cyc(32'h4180, 1, 0, "exc_prio");

        rst = 1'b1;
        cyc(32'h3000, 0, 0, "reset2");
        cyc(32'h3004, 0, 0, "seq7");
        cyc(32'h3008, 0, 0, "seq8");

        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; br_taken = 1'b1; br_offset = 32'hFFFF_FFF0;
            cyc(32'h3008, 0, 0, "stall_hold");
        end
        stall = 1'b1; exc_valid = 1'b1;
        cyc(32'h4180, 1, 0, "stall_exc");
        cyc(32'h4184, 0, 0, "exc_after");

        jr_valid = 1'b1; jr_target = 32'hFFFF_FFFC;
`ifdef DELAY_SLOT_EN
        cyc(32'h4188, 0, 0, "jr_top_slot");
        cyc(32'hFFFF_FFFC, 0, 0, "jr_top");
`else
        cyc(32'hFFFF_FFFC, 1, 0, "jr_top");
`endif
        cyc(32'h0000_0000, 0, 0, "wrap");

        br_taken = 1'b1; br_offset = 32'h20;
`ifdef DELAY_SLOT_EN
        cyc(32'h4, 0, 0, "br2_slot");
`else
        cyc(32'h24, 1, 0, "br2");
`endif
        rst = 1'b1;
        cyc(32'h3000, 0, 0, "rst_in_slot");
        cyc(32'h3004, 0, 0, "tgt_lost");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npc_unit.md
# npc_unit

Program-counter register and next-PC sequencer for the MIPS-style core. It consumes the 32-bit shifted, sign-extended branch offset from the immediate extender, together with jump, jump-register and exception requests from decode/execute. It produces the registered fetch PC. Delay-slot semantics are selectable at compile time.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_PC, 32'h0000_4180, exception vector.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- stall  input  1  hold PC and state.
- br_taken  input  1  branch resolved taken for the instruction at `pc`.
- br_offset  input  32  byte offset, already sign-extended and <<2.
- j_valid  input  1  J/JAL at `pc`.
- j_index  input  26  instr_index field.
- jr_valid  input  1  JR/JALR at `pc`.
- jr_target  input  32  register target.
- exc_valid  input  1  exception request.
- pc  output  32  current fetch PC (registered).
- pc_plus4  output  32  pc + 4, combinational (link value).
- flush  output  1  squash the instruction fetched after a redirect (registered pulse).
- misalign  output  1  one-cycle pulse: JR target not word-aligned.

## Operation
- Targets, all mod 2^32:
  - br: pc_plus4 + br_offset.
  - j: {pc_plus4[31:28], j_index, 2'b00}.
  - jr: jr_target.
  - exc: EXC_PC.
- Priority: exc > jr > j > br > sequential (pc_plus4).
- jr_valid with jr_target[1:0] != 0 is treated as an exception:
  - pc <= EXC_PC.
  - misalign = 1 for one cycle.
- States: RUN, DSLOT. Registered pending target `tgt`.
- RUN, no stall, redirect (jr/j/br) requested:
  - DELAY_SLOT_EN builds: tgt <= target, pc <= pc_plus4, state -> DSLOT.
  - Otherwise: pc <= target, flush <= 1.
- DSLOT, no stall: pc <= tgt, state -> RUN.
  - jr/j/br requests in DSLOT are ignored (branch-in-delay-slot is unsupported).
- exc_valid, in any state and regardless of stall:
  - pc <= EXC_PC, state -> RUN, tgt cleared, flush <= 1.
- stall = 1 without exc: pc, state and tgt hold; flush <= 0; jr/j/br requests are ignored.

## Timing
- Reset values:
  - pc = RESET_PC, state = RUN, tgt = 0.
  - flush = 0, misalign = 0.
  - pc_plus4 = RESET_PC + 4.
- All requests are sampled at the clock edge and refer to the instruction at the current `pc`. The new pc is visible the cycle after.
- flush and misalign are registered: high exactly in the cycle the redirected pc is visible, low otherwise.
- Redirect latency:
  - No-delay-slot build: 1 cycle.
  - Delay-slot build: 2 cycles, with pc_plus4 visible in between.
- Simultaneous requests: only the highest priority is honored; the others are dropped, not queued.
- Reset asserted mid-DSLOT: pending target is discarded and pc = RESET_PC next cycle.
- Wrap-around: pc 32'hFFFF_FFFC sequences to 32'h0000_0000; no fault is raised.

## Configuration
- DELAY_SLOT_EN defined:
  - Architectural single delay slot; DSLOT state is present.
  - flush is asserted only for exceptions.
- DELAY_SLOT_EN undefined:
  - DSLOT state and tgt register are removed.
  - Every taken redirect is immediate and pulses flush.

## Test plan
- Reset, stall = 0, no requests, 4 cycles:
  - pc = 3000, 3004, 3008, 300C.
  - flush = 0 throughout.
- pc = 3010, br_taken = 1, br_offset = 32'hFFFF_FFF0 (−16):
  - DELAY_SLOT_EN: pc = 3014, then 3004.
  - Without: pc = 3004 next cycle, flush = 1 for that one cycle.
- pc = 3010, j_valid = 1 and br_taken = 1 together, j_index = 26'h0000C10:
  - Target = 3040; the branch is ignored.
- jr_valid = 1, jr_target = 32'h0000_3021:
  - pc = 4180 next cycle.
  - misalign = 1 and flush = 1 for one cycle.
- stall = 1 for 3 cycles at pc = 3008 with br_taken = 1:
  - pc holds at 3008, no redirect.
  - Then exc_valid = 1 while stalled: pc = 4180 next cycle.
- DELAY_SLOT_EN, rst asserted in the DSLOT cycle after a branch: pc = 3000, pending target lost.
